// File: rtl/axis_crypto_pkg.sv
// axis_crypto_pkg: shared state encoding, frame geometry defaults, field widths and block record type
package axis_crypto_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    localparam int HDR_WORDS_DEF  = 12;
    localparam int DATA_WORDS_DEF = 16;
    localparam int WORD_W         = 32;
    localparam int IDX_W          = 5;
    localparam int KEY_W          = 256;
    localparam int NONCE_W        = 64;
    localparam int CTR_W          = 64;
    localparam int BLK_W          = 512;

    // One captured block plus the frame mode it was offered with
    typedef struct packed {
        logic [BLK_W-1:0]   data;
        logic [KEY_W-1:0]   key;
        logic [NONCE_W-1:0] nonce;
        logic [CTR_W-1:0]   ctr;
        logic               mode;
    } blk_t;

endpackage

// File: rtl/axis_block_serializer_if.sv
// axis_block_serializer_if: block input channel and AXI4-Stream output channel of the serializer
//   master : serializer view (accepts blocks, drives the stream, reports busy)
//   slave  : environment view (offers blocks, sinks the stream)
interface axis_block_serializer_if;
    import axis_crypto_pkg::*;

    logic                encryp_decryp;
    logic                blk_valid;
    logic                blk_ready;
    logic [BLK_W-1:0]    blk_data;
    logic [KEY_W-1:0]    blk_key;
    logic [NONCE_W-1:0]  blk_nonce;
    logic [CTR_W-1:0]    blk_ctr;
    logic                m_axis_valid;
    logic                m_axis_ready;
    logic [WORD_W-1:0]   m_axis_data;
    logic                m_axis_last;
    logic                busy;

    modport master (
        input  encryp_decryp, blk_valid, blk_data, blk_key, blk_nonce, blk_ctr, m_axis_ready,
        output blk_ready, m_axis_valid, m_axis_data, m_axis_last, busy
    );

    modport slave (
        output encryp_decryp, blk_valid, blk_data, blk_key, blk_nonce, blk_ctr, m_axis_ready,
        input  blk_ready, m_axis_valid, m_axis_data, m_axis_last, busy
    );

endinterface

// File: rtl/axis_ser_buf.sv
// axis_ser_buf: holds one captured block (data, key, nonce, ctr, mode) with a valid flag
//   axis_clk, axis_reset_n : clock, async active-low reset (clears contents)
//   load_i / blk_i         : capture blk_i and set valid (load wins over clear)
//   clr_i                  : drop valid
//   valid_o / blk_o        : held block
module axis_ser_buf import axis_crypto_pkg::*; (
    input  logic axis_clk,
    input  logic axis_reset_n,
    input  logic load_i,
    input  logic clr_i,
    input  blk_t blk_i,
    output logic valid_o,
    output blk_t blk_o
);

    logic valid_q, valid_d;
    blk_t blk_q, blk_d;

    always_comb begin
        valid_d = load_i | (valid_q & ~clr_i);
        blk_d   = load_i ? blk_i : blk_q;
    end

    always_ff @(posedge axis_clk or negedge axis_reset_n) begin
        if (!axis_reset_n) begin
            valid_q <= 1'b0;
            blk_q   <= '0;
        end else begin
            valid_q <= valid_d;
            blk_q   <= blk_d;
        end
    end

    assign valid_o = valid_q;
    assign blk_o   = blk_q;

endmodule

// File: rtl/axis_block_serializer.sv
// axis_block_serializer: serializes a 512-bit block (optionally preceded by key/nonce/counter header) into 32-bit MSB-first AXI4-Stream beats
//   axis_clk, axis_reset_n : clock, async active-low reset
//   bus (master)           : blk_* input channel with encryp_decryp, m_axis_* stream output, busy
//   AXIS_SER_DOUBLE_BUF_EN : adds a pending block slot so the next block is accepted mid-frame and streams with no gap
module axis_block_serializer import axis_crypto_pkg::*; #(
    parameter int HDR_WORDS  = HDR_WORDS_DEF,
    parameter int DATA_WORDS = DATA_WORDS_DEF
) (
    input logic                     axis_clk,
    input logic                     axis_reset_n,
    axis_block_serializer_if.master bus
);

    logic [1:0]                     state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic                           valid_q, valid_d, last_q, last_d;
    logic                           ready_q, ready_d, busy_q, busy_d;
    logic [WORD_W-1:0]              data_q, data_d;
    logic                           accept, hs, end_frame, start, cur_v, pend_nxt;
    blk_t                           in_blk, cur_blk, src_blk, nxt_blk;
    logic [KEY_W+NONCE_W+CTR_W-1:0] hdr;

    assign in_blk    = '{data: bus.blk_data, key: bus.blk_key, nonce: bus.blk_nonce,
                         ctr: bus.blk_ctr, mode: bus.encryp_decryp};
    assign accept    = bus.blk_valid & ready_q;
    assign hs        = valid_q & bus.m_axis_ready;
    assign end_frame = hs & (state_q == S_DATA) & (idx_q == IDX_W'(DATA_WORDS - 1));

`ifdef AXIS_SER_DOUBLE_BUF_EN
    blk_t pend_blk;
    logic pend_v, load_pend;

    // A block arriving while a frame runs parks in the pending slot, unless the
    // frame ends on this very edge, in which case it starts directly.
    assign load_pend = accept & cur_v & ~end_frame;
    assign start     = (accept & ~cur_v) | (end_frame & (pend_v | accept));
    assign src_blk   = pend_v ? pend_blk : in_blk;
    assign pend_nxt  = load_pend | (pend_v & ~end_frame);
    assign ready_d   = ~pend_nxt;

    axis_ser_buf u_pend (
        .axis_clk     (axis_clk),
        .axis_reset_n (axis_reset_n),
        .load_i       (load_pend),
        .clr_i        (end_frame),
        .blk_i        (in_blk),
        .valid_o      (pend_v),
        .blk_o        (pend_blk)
    );
`else
    assign start    = accept & ~cur_v;
    assign src_blk  = in_blk;
    assign pend_nxt = 1'b0;
    assign ready_d  = state_d == S_IDLE;
`endif

    axis_ser_buf u_cur (
        .axis_clk     (axis_clk),
        .axis_reset_n (axis_reset_n),
        .load_i       (start),
        .clr_i        (end_frame),
        .blk_i        (src_blk),
        .valid_o      (cur_v),
        .blk_o        (cur_blk)
    );

    // Outputs are computed from next-state values so the first beat is
    // registered on the accept edge itself.
    assign nxt_blk = start ? src_blk : cur_blk;
    assign hdr     = {nxt_blk.key, nxt_blk.nonce, nxt_blk.ctr};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (start) begin
            state_d = nxt_blk.mode ? S_DATA : S_HDR;
            idx_d   = '0;
        end else if (end_frame) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end else if (hs) begin
            state_d = (state_q == S_HDR && idx_q == IDX_W'(HDR_WORDS - 1)) ? S_DATA : state_q;
            idx_d   = (state_q == S_HDR && idx_q == IDX_W'(HDR_WORDS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        valid_d = state_d != S_IDLE;
        last_d  = (state_d == S_DATA) & (idx_d == IDX_W'(DATA_WORDS - 1));
        data_d  = (state_d == S_HDR)  ? WORD_W'(hdr >> (WORD_W * (HDR_WORDS - 1 - int'(idx_d)))) :
                  (state_d == S_DATA) ? WORD_W'(nxt_blk.data >> (WORD_W * (DATA_WORDS - 1 - int'(idx_d)))) :
                  '0;
        busy_d  = valid_d | pend_nxt;
    end

    always_ff @(posedge axis_clk or negedge axis_reset_n) begin
        if (!axis_reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.blk_ready    = ready_q;
    assign bus.m_axis_valid = valid_q;
    assign bus.m_axis_data  = data_q;
    assign bus.m_axis_last  = last_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_axis_block_serializer.sv
// tb_axis_block_serializer: randomized and directed stimulus against a beat-queue reference model
module tb_axis_block_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    axis_block_serializer_if bus();

    axis_block_serializer dut (
        .axis_clk     (clk),
        .axis_reset_n (rst_n),
        .bus          (bus)
    );

`ifdef AXIS_SER_DOUBLE_BUF_EN
    localparam int LIM = 2;
`else
    localparam int LIM = 1;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t       q[$];
    logic [31:0] got_d[$];
    logic        got_l[$];
    int          hs_cyc[$];
    int          checks = 0;
    int          errors = 0;
    int          lasts = 0;
    int          cyc = 0;
    logic        armed = 1'b0;
    logic        rnd_ready = 1'b0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: an accepted block expands into its complete beat list
    task automatic push_block(input logic m, input logic [511:0] d, input logic [255:0] k,
                              input logic [63:0] n, input logic [63:0] c);
        if (!m) begin
            for (int i = 0; i < 8; i++) q.push_back('{k[255-32*i -: 32], 1'b0});
            q.push_back('{n[63:32], 1'b0});
            q.push_back('{n[31:0], 1'b0});
            q.push_back('{c[63:32], 1'b0});
            q.push_back('{c[31:0], 1'b0});
        end
        for (int i = 0; i < 16; i++) q.push_back('{d[511-32*i -: 32], i == 15});
        lasts++;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed <= 1'b0;
        else armed <= 1'b1;
    end

    always begin
        @(posedge clk);
        #1;
        bus.m_axis_ready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    end

    // Compare process: outputs sampled on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            lasts = 0;
            chk1("rst_valid", bus.m_axis_valid, 1'b0);
            chk1("rst_ready", bus.blk_ready, 1'b0);
            chk1("rst_busy", bus.busy, 1'b0);
        end else begin
            chk1("valid", bus.m_axis_valid, q.size() != 0);
            chk1("busy", bus.busy, q.size() != 0);
            chk1("blk_ready", bus.blk_ready, armed && lasts < LIM);
            if (bus.m_axis_valid && q.size() != 0) begin
                chk32("data", bus.m_axis_data, q[0].d);
                chk1("last", bus.m_axis_last, q[0].l);
            end
            if (bus.m_axis_valid && bus.m_axis_ready && q.size() != 0) begin
                got_d.push_back(bus.m_axis_data);
                got_l.push_back(bus.m_axis_last);
                hs_cyc.push_back(cyc);
                if (q[0].l) lasts--;
                void'(q.pop_front());
            end
            if (bus.blk_valid && bus.blk_ready)
                push_block(bus.encryp_decryp, bus.blk_data, bus.blk_key, bus.blk_nonce, bus.blk_ctr);
        end
    end

    function automatic logic [511:0] r512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [255:0] r256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    task automatic send(input logic m, input logic [511:0] d, input logic [255:0] k,
                        input logic [63:0] n, input logic [63:0] c);
        int t = 0;
        bus.encryp_decryp = m;
        bus.blk_data      = d;
        bus.blk_key       = k;
        bus.blk_nonce     = n;
        bus.blk_ctr       = c;
        bus.blk_valid     = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.blk_ready && t < 3000);
        if (t >= 3000) chk1("accept_timeout", bus.blk_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.blk_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0) break;
        end
        chk32("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic wait_got(input int n);
        for (int t = 0; t < 3000; t++) begin
            if (got_d.size() >= n) break;
            @(posedge clk);
            #1;
        end
        if (got_d.size() < n) chk32("wait_timeout", 32'(got_d.size()), 32'(n));
    endtask

    task automatic clear();
        got_d.delete();
        got_l.delete();
        hs_cyc.delete();
    endtask

    function automatic int count_last();
        int s = 0;
        foreach (got_l[i]) s += int'(got_l[i]);
        return s;
    endfunction

    logic [511:0] dat, dat2;
    logic [255:0] key;
    logic [63:0]  nonce, ctr;
    int           exp_len;
    logic         m;

    initial begin
        bus.blk_valid     = 1'b0;
        bus.encryp_decryp = 1'b0;
        bus.blk_data      = '0;
        bus.blk_key       = '0;
        bus.blk_nonce     = '0;
        bus.blk_ctr       = '0;
        key   = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
        nonce = 64'hAAAAAAAA_BBBBBBBB;
        ctr   = 64'h00000000_00000005;

        #1 rst_n = 1'b0;
        #1;
        chk1("reset_valid", bus.m_axis_valid, 1'b0);
        chk32("reset_data", bus.m_axis_data, 32'h0);
        chk1("reset_last", bus.m_axis_last, 1'b0);
        chk1("reset_ready", bus.blk_ready, 1'b0);
        chk1("reset_busy", bus.busy, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk1("ready_after_release", bus.blk_ready, 1'b1);

        // Decryption frame, counting payload words
        dat = '0;
        for (int i = 0; i < 16; i++) dat[511-32*i -: 32] = 32'(i);
        clear();
        send(1'b1, dat, r256(), r64(), r64());
        drain();
        chk32("m1_len", 32'(got_d.size()), 32'd16);
        for (int i = 0; i < 16 && i < got_d.size(); i++) begin
            chk32("m1_beat", got_d[i], 32'(i));
            chk1("m1_last", got_l[i], i == 15);
        end

        // Encryption frame with recognisable header
        dat = r512();
        clear();
        send(1'b0, dat, key, nonce, ctr);
        drain();
        chk32("m0_len", 32'(got_d.size()), 32'd28);
        if (got_d.size() == 28) begin
            chk32("m0_key0", got_d[0], 32'h11111111);
            chk32("m0_key7", got_d[7], 32'h88888888);
            chk32("m0_nonce_hi", got_d[8], 32'hAAAAAAAA);
            chk32("m0_nonce_lo", got_d[9], 32'hBBBBBBBB);
            chk32("m0_ctr_hi", got_d[10], 32'h00000000);
            chk32("m0_ctr_lo", got_d[11], 32'h00000005);
            chk32("m0_data0", got_d[12], dat[511:480]);
            chk1("m0_last27", got_l[27], 1'b1);
        end
        chk32("m0_last_count", 32'(count_last()), 32'd1);

        // Random backpressure over four frames of random mode
        rnd_ready = 1'b1;
        clear();
        exp_len = 0;
        for (int f = 0; f < 4; f++) begin
            m = 1'($urandom_range(1, 0));
            exp_len += m ? 16 : 28;
            send(m, r512(), r256(), r64(), r64());
        end
        drain();
        rnd_ready = 1'b0;
        chk32("rnd_len", 32'(got_d.size()), 32'(exp_len));
        chk32("rnd_last_count", 32'(count_last()), 32'd4);

        // Mode input changing mid-frame is ignored until the next accept
        clear();
        send(1'b0, r512(), key, nonce, ctr);
        wait_got(3);
        bus.encryp_decryp = 1'b1;
        drain();
        chk32("toggle_len", 32'(got_d.size()), 32'd28);
        clear();
        send(bus.encryp_decryp, r512(), r256(), r64(), r64());
        drain();
        chk32("toggle_next_len", 32'(got_d.size()), 32'd16);

        // Reset in the middle of an encryption frame
        clear();
        send(1'b0, r512(), r256(), r64(), r64());
        wait_got(9);
        rst_n = 1'b0;
        #1;
        chk1("midrst_valid", bus.m_axis_valid, 1'b0);
        chk1("midrst_last", bus.m_axis_last, 1'b0);
        chk32("midrst_data", bus.m_axis_data, 32'h0);
        chk1("midrst_busy", bus.busy, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear();
        send(1'b0, r512(), key, nonce, ctr);
        drain();
        chk32("postrst_len", 32'(got_d.size()), 32'd28);
        if (got_d.size() != 0) chk32("postrst_beat0", got_d[0], 32'h11111111);

        // Two blocks offered back-to-back with the sink always ready
        dat  = r512();
        dat2 = r512();
        clear();
        send(1'b0, dat, r256(), r64(), r64());
        send(1'b0, dat2, r256(), r64(), r64());
        drain();
        chk32("b2b_len", 32'(got_d.size()), 32'd56);
        if (hs_cyc.size() == 56)
            chk32("b2b_span", 32'(hs_cyc[55] - hs_cyc[0]), (LIM == 2) ? 32'd55 : 32'd56);
        if (got_d.size() == 56) chk32("b2b_second_data0", got_d[40], dat2[511:480]);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_block_serializer.md
AXIS_BLOCK_SERIALIZER -- requirements
Module: axis_block_serializer

Interface
REQ-001 SHALL have parameter HDR_WORDS, default 12: header beats in encryption mode (8 key, 2 nonce, 2 counter).
REQ-002 SHALL have parameter DATA_WORDS, default 16: payload beats per 512-bit block.
REQ-003 SHALL have port axis_clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port axis_reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port encryp_decryp  in  1  0 = encryption frame (header + payload), 1 = decryption frame (payload only).
REQ-006 SHALL have port blk_valid  in  1  upstream block present.
REQ-007 SHALL have port blk_ready  out  1  block accepted on the edge where blk_valid and blk_ready are both high.
REQ-008 SHALL have ports blk_data in 512, blk_key in 256, blk_nonce in 64, blk_ctr in 64: ChaCha output block and its session parameters.
REQ-009 SHALL have port m_axis_ready  in  1  downstream ready.
REQ-010 SHALL have ports m_axis_valid out 1, m_axis_data out 32, m_axis_last out 1: AXI4-Stream master, MSB-first words.
REQ-011 SHALL have port busy  out  1  high whenever a frame is in flight or buffered.

Function
REQ-012 SHALL implement FSM states IDLE, HDR, DATA, with a 5-bit beat index.
REQ-013 In IDLE, blk_ready=1; on accept, SHALL register all block inputs and encryp_decryp, then go to HDR (mode 0) or DATA (mode 1), with index 0.
REQ-014 Latency: first beat SHALL be valid on the cycle after the accept edge; all outputs SHALL be registered.
REQ-015 HDR beat order SHALL be key[255:224]..key[31:0], nonce[63:32], nonce[31:0], ctr[63:32], ctr[31:0].
REQ-016 DATA beat order SHALL be data[511:480] first, through data[31:0] last.
REQ-017 Index SHALL advance only on a handshake (m_axis_valid and m_axis_ready); HDR->DATA after beat HDR_WORDS-1; DATA->IDLE after beat DATA_WORDS-1.
REQ-018 While m_axis_valid=1 and m_axis_ready=0, m_axis_data and m_axis_last SHALL hold stable, and valid SHALL NOT drop.
REQ-019 m_axis_last SHALL be 1 only on the final DATA beat; frame length is 28 beats in mode 0 and 16 in mode 1.
REQ-020 A change of encryp_decryp mid-frame SHALL be ignored until the next accept.
REQ-021 Without the REQ-028 feature, blk_ready SHALL be 0 in HDR and DATA, giving one IDLE cycle between frames.
REQ-022 blk_valid with blk_ready=0 SHALL have no effect; upstream holds its data.

Reset
REQ-023 On axis_reset_n low, SHALL immediately set: state IDLE, index 0, m_axis_valid 0, m_axis_data 0, m_axis_last 0, busy 0, and clear all buffers.
REQ-024 blk_ready SHALL be 0 while reset is asserted and 1 on the first edge after release.
REQ-025 Reset mid-frame SHALL discard the frame; no partial continuation after release.

Configuration
REQ-026 Macro AXIS_SER_DOUBLE_BUF_EN SHALL select a second block buffer (pending slot).
REQ-027 Undefined: single buffer, behaviour per REQ-021.
REQ-028 Defined: blk_ready = pending slot empty, so a block is accepted during an active frame. After the last handshake, a pending frame's first beat SHALL be valid on the next cycle with zero idle cycles. Mode is captured per block at accept.

Structure
REQ-029 Shared package axis_crypto_pkg SHALL hold state encoding, HDR_WORDS/DATA_WORDS defaults, and the key/nonce/counter/block width constants.
REQ-030 Sub-module axis_ser_buf SHALL hold one captured block (data, key, nonce, ctr, mode) with load/valid; instantiated once, or twice under the macro.

Verification
REQ-031 Mode 1, blk_data = 0x00000000_00000001_..._0000000F words, m_axis_ready=1 -> 16 beats 0x0..0xF, last on beat 15, valid the cycle after accept.
REQ-032 Mode 0, key=0x11..1_..._88..8, nonce=0xAAAAAAAA_BBBBBBBB, ctr=0x0_00000005 -> beats 0x11111111..0x88888888, 0xAAAAAAAA, 0xBBBBBBBB, 0x0, 0x5, then 16 payload beats; 28 total.
REQ-033 Random m_axis_ready (50%) over 4 frames -> no beat lost or duplicated, data stable during stalls, exactly 4 last beats.
REQ-034 axis_reset_n low at beat 9 of a mode-0 frame -> valid drops immediately; after release, a new block streams from header beat 0.
REQ-035 Toggle encryp_decryp at beat 3 of a mode-0 frame -> frame still 28 beats; next frame uses the new mode.
REQ-036 With AXIS_SER_DOUBLE_BUF_EN, two blocks offered back-to-back -> second accepted mid-frame, 56 contiguous beats with no gap when m_axis_ready=1. Without the macro -> one idle cycle between frames.
